// File: rtl/spi_burst_arbiter.sv
// Round-robin sequencer that shares one 8-bit spi_master between two requesters.
// Each grant runs a chip-select-framed burst of len+1 bytes at the winner's SCLK divider.
module spi_burst_arbiter #(
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int ACK_TO   = 0
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [1:0]         req,
  input  logic [2*LEN_W-1:0] len,
  input  logic [31:0]        div_cfg,
  input  logic [15:0]        tx_data,
  output logic [1:0]         tx_rd,
  output logic [1:0]         grant,
  output logic [7:0]         rx_data,
  output logic [1:0]         rx_vld,
  output logic [1:0]         done,
  output logic [1:0]         err,
  output logic               busy,
  output logic               spi_cs_ctrl,
  output logic [15:0]        spi_clk_div_val,
  output logic               spi_wr_req,
  input  logic               spi_wr_ack,
  output logic [7:0]         spi_data_tx,
  input  logic [7:0]         spi_data_rx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    GAP   = 3'd4,
    HOLD  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int TMR_W = 16;
  // LOAD and the DONE entry edge each supply one cycle of the setup/hold windows.
  localparam logic [TMR_W-1:0] SETUP_END = TMR_W'((CS_SETUP > 2) ? CS_SETUP - 2 : 0);
  localparam logic [TMR_W-1:0] HOLD_END  = TMR_W'((CS_HOLD > 2) ? CS_HOLD - 2 : 0);
  localparam logic [TMR_W-1:0] TO_END    = TMR_W'((ACK_TO > 1) ? ACK_TO - 1 : 0);

  state_t             state_r, state_s;
  logic [TMR_W-1:0]   tmr_r, tmr_s;
  logic [LEN_W-1:0]   byte_cnt_r, byte_cnt_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic               owner_r, owner_s;
  logic               last_r, last_s;
  logic               abort_r, abort_s;
  logic               win_s;
  logic [1:0]         grant_r, grant_s;
  logic               cs_r, cs_s;
  logic [15:0]        div_r, div_s;
  logic [7:0]         data_tx_r, data_tx_s;
  logic [7:0]         rx_data_r, rx_data_s;
  logic [1:0]         tx_rd_r, tx_rd_s;
  logic [1:0]         rx_vld_r, rx_vld_s;
  logic [1:0]         done_r, done_s;
  logic [1:0]         err_r, err_s;
  logic               wr_req_r, wr_req_s;
  logic               busy_r, busy_s;

  // Next-state and next-output computation; outputs are registered for the state being entered.
  always_comb begin
    state_s    = state_r;
    tmr_s      = tmr_r;
    byte_cnt_s = byte_cnt_r;
    len_s      = len_r;
    owner_s    = owner_r;
    last_s     = last_r;
    abort_s    = abort_r;
    win_s      = 1'b0;
    grant_s    = grant_r;
    cs_s       = cs_r;
    div_s      = div_r;
    data_tx_s  = data_tx_r;
    rx_data_s  = rx_data_r;
    rx_vld_s   = 2'b00;
    tx_rd_s    = 2'b00;
    done_s     = 2'b00;
    err_s      = 2'b00;

    case (state_r)
      IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) begin
            win_s = ~last_r;
          end else begin
            win_s = req[1];
          end
          owner_s    = win_s;
          grant_s    = win_s ? 2'b10 : 2'b01;
          len_s      = win_s ? len[2*LEN_W-1 -: LEN_W] : len[LEN_W-1:0];
          div_s      = win_s ? div_cfg[31:16] : div_cfg[15:0];
          cs_s       = 1'b0;
          byte_cnt_s = {LEN_W{1'b0}};
          abort_s    = 1'b0;
          tmr_s      = {TMR_W{1'b0}};
          state_s    = (CS_SETUP > 1) ? SETUP : LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (tmr_r == SETUP_END) begin
          tmr_s   = {TMR_W{1'b0}};
          state_s = LOAD;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end
      LOAD: begin
        tmr_s   = {TMR_W{1'b0}};
        state_s = ISSUE;
      end
      ISSUE: begin
        if (spi_wr_ack) begin
          rx_data_s = spi_data_rx;
          rx_vld_s  = grant_r;
          tmr_s     = {TMR_W{1'b0}};
          if (byte_cnt_r == len_r) begin
            state_s = (CS_HOLD > 1) ? HOLD : DONE;
          end else begin
            byte_cnt_s = byte_cnt_r + LEN_W'(1);
            state_s    = GAP;
          end
        end else if ((ACK_TO != 0) && (tmr_r == TO_END)) begin
          abort_s = 1'b1;
          tmr_s   = {TMR_W{1'b0}};
          state_s = (CS_HOLD > 1) ? HOLD : DONE;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end
      GAP: begin
        state_s = LOAD;
      end
      HOLD: begin
        if (tmr_r == HOLD_END) begin
          tmr_s   = {TMR_W{1'b0}};
          state_s = DONE;
        end else begin
          tmr_s = tmr_r + TMR_W'(1);
        end
      end
      DONE: begin
        grant_s = 2'b00;
        last_s  = owner_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        grant_s = 2'b00;
        cs_s    = 1'b1;
      end
    endcase

    if (state_s == LOAD) begin
      tx_rd_s   = grant_s;
      data_tx_s = owner_s ? tx_data[15:8] : tx_data[7:0];
    end else begin
      tx_rd_s = 2'b00;
    end

    if (state_s == DONE) begin
      cs_s   = 1'b1;
      done_s = grant_r;
      err_s  = abort_s ? grant_r : 2'b00;
    end else begin
      done_s = 2'b00;
      err_s  = 2'b00;
    end

    wr_req_s = (state_s == ISSUE);
    busy_s   = (state_s != IDLE);
  end

  // State and output registers with synchronous reset; pointer resets to favour requester 0.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r    <= IDLE;
      tmr_r      <= {TMR_W{1'b0}};
      byte_cnt_r <= {LEN_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      owner_r    <= 1'b0;
      last_r     <= 1'b1;
      abort_r    <= 1'b0;
      grant_r    <= 2'b00;
      cs_r       <= 1'b1;
      div_r      <= 16'h0000;
      data_tx_r  <= 8'h00;
      rx_data_r  <= 8'h00;
      tx_rd_r    <= 2'b00;
      rx_vld_r   <= 2'b00;
      done_r     <= 2'b00;
      err_r      <= 2'b00;
      wr_req_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      tmr_r      <= tmr_s;
      byte_cnt_r <= byte_cnt_s;
      len_r      <= len_s;
      owner_r    <= owner_s;
      last_r     <= last_s;
      abort_r    <= abort_s;
      grant_r    <= grant_s;
      cs_r       <= cs_s;
      div_r      <= div_s;
      data_tx_r  <= data_tx_s;
      rx_data_r  <= rx_data_s;
      tx_rd_r    <= tx_rd_s;
      rx_vld_r   <= rx_vld_s;
      done_r     <= done_s;
      err_r      <= err_s;
      wr_req_r   <= wr_req_s;
      busy_r     <= busy_s;
    end
  end

  assign tx_rd           = tx_rd_r;
  assign grant           = grant_r;
  assign rx_data         = rx_data_r;
  assign rx_vld          = rx_vld_r;
  assign done            = done_r;
  assign err             = err_r;
  assign busy            = busy_r;
  assign spi_cs_ctrl     = cs_r;
  assign spi_clk_div_val = div_r;
  assign spi_wr_req      = wr_req_r;
  assign spi_data_tx     = data_tx_r;

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed bench for spi_burst_arbiter: the bench plays the spi_master slave side,
// and received bytes are checked through a scoreboard queue.
module tb_spi_burst_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  req;
  logic [7:0]  len;
  logic [31:0] div_cfg;
  logic [15:0] tx_data;
  logic [1:0]  tx_rd, grant, rx_vld, done, err;
  logic [7:0]  rx_data;
  logic        busy, spi_cs_ctrl, spi_wr_req, spi_wr_ack;
  logic [15:0] spi_clk_div_val;
  logic [7:0]  spi_data_tx, spi_data_rx;

  int n_vec = 0;
  int n_err = 0;
  int txrd_cnt [2];
  int done_cnt [2];
  logic [8:0]  sb_q [$];
  logic [15:0] exp_div [2];

  always #5 sys_clk = ~sys_clk;

  spi_burst_arbiter #(.LEN_W(4), .CS_SETUP(4), .CS_HOLD(4), .ACK_TO(32)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .len(len), .div_cfg(div_cfg),
    .tx_data(tx_data), .tx_rd(tx_rd), .grant(grant), .rx_data(rx_data), .rx_vld(rx_vld),
    .done(done), .err(err), .busy(busy), .spi_cs_ctrl(spi_cs_ctrl),
    .spi_clk_div_val(spi_clk_div_val), .spi_wr_req(spi_wr_req), .spi_wr_ack(spi_wr_ack),
    .spi_data_tx(spi_data_tx), .spi_data_rx(spi_data_rx)
  );

  // Pulse counters sampled on the inactive edge.
  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_rd[i]) txrd_cnt[i]++;
      if (done[i])  done_cnt[i]++;
    end
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (spi_wr_req !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic set_tx(input int g, input logic [7:0] v);
    if (g == 1) tx_data[15:8] = v;
    else        tx_data[7:0]  = v;
  endtask

  // Slave side: hold ack off for dly cycles, then pulse ack with rxb.
  task automatic xfer(input int g, input logic [7:0] rxb, input int dly);
    logic [8:0] e;
    repeat (dly) begin
      tick;
      chk("wr_req_held", {31'd0, spi_wr_req}, 32'd1);
    end
    spi_data_rx = rxb;
    spi_wr_ack  = 1'b1;
    sb_q.push_back({g[0], rxb});
    tick;
    spi_wr_ack  = 1'b0;
    spi_data_rx = 8'h00;
    chk("wr_req_drop", {31'd0, spi_wr_req}, 32'd0);
    if (rx_vld !== 2'b00 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rx_vld", {30'd0, rx_vld}, e[8] ? 32'd2 : 32'd1);
      chk("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
    end else begin
      chk("rx_vld_missing", {30'd0, rx_vld}, (g == 1) ? 32'd2 : 32'd1);
    end
  endtask

  task automatic burst(input int g, input int nb, input logic [7:0] seed, input bit drop);
    int n;
    int base_rd;
    logic [7:0] b;
    logic [31:0] oh;
    oh = (g == 1) ? 32'd2 : 32'd1;
    n = 0;
    while (grant === 2'b00 && n < 50) begin
      tick;
      n++;
    end
    chk("grant", {30'd0, grant}, oh);
    chk("cs_low_at_grant", {31'd0, spi_cs_ctrl}, 32'd0);
    chk("busy", {31'd0, busy}, 32'd1);
    chk("div_at_grant", {16'd0, spi_clk_div_val}, {16'd0, exp_div[g]});
    base_rd = txrd_cnt[g];
    set_tx(g, seed);
    for (int k = 0; k < nb; k++) begin
      b = seed + 8'(k);
      wait_req(n);
      chk((k == 0) ? "setup_delay" : "byte_gap", n, (k == 0) ? 32'd4 : 32'd2);
      chk("data_tx", {24'd0, spi_data_tx}, {24'd0, b});
      chk("cs_low_in_burst", {31'd0, spi_cs_ctrl}, 32'd0);
      chk("div_in_burst", {16'd0, spi_clk_div_val}, {16'd0, exp_div[g]});
      set_tx(g, b + 8'd1);
      xfer(g, b ^ 8'h99, k % 3);
    end
    repeat (2) begin
      tick;
      chk("cs_hold_low", {31'd0, spi_cs_ctrl}, 32'd0);
    end
    tick;
    chk("cs_rise", {31'd0, spi_cs_ctrl}, 32'd1);
    chk("done", {30'd0, done}, oh);
    chk("err_clear", {30'd0, err}, 32'd0);
    chk("grant_in_done", {30'd0, grant}, oh);
    if (drop) req = 2'b00;
    tick;
    chk("grant_cleared", {30'd0, grant}, 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
    chk("tx_rd_count", txrd_cnt[g] - base_rd, nb);
  endtask

  initial begin
    int n;
    int dc;
    sys_rst = 1'b1; req = 2'b00; len = 8'h00; div_cfg = {16'd9, 16'd2};
    tx_data = 16'h0000; spi_wr_ack = 1'b0; spi_data_rx = 8'h00;
    exp_div[0] = 16'd2; exp_div[1] = 16'd9;
    repeat (3) tick;
    chk("rst_cs", {31'd0, spi_cs_ctrl}, 32'd1);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_req", {31'd0, spi_wr_req}, 32'd0);
    chk("rst_div", {16'd0, spi_clk_div_val}, 32'd0);
    chk("rst_strobes", {24'd0, tx_rd, rx_vld, done, err}, 32'd0);
    sys_rst = 1'b0;
    tick;
    chk("idle_cs", {31'd0, spi_cs_ctrl}, 32'd1);

    // Single byte, requester 0.
    len = {4'd0, 4'd0}; req = 2'b01;
    burst(0, 1, 8'hA5, 1'b1);
    chk("div_holds_0", {16'd0, spi_clk_div_val}, 32'd2);

    // Four bytes, requester 1.
    len = {4'd3, 4'd0}; req = 2'b10;
    burst(1, 4, 8'h01, 1'b1);
    chk("tx_rd_other_silent", txrd_cnt[0], 32'd1);

    // Both requesting after reset: strict alternation, divider follows owner.
    sys_rst = 1'b1; tick; sys_rst = 1'b0;
    len = {4'd1, 4'd2}; req = 2'b11;
    burst(0, 3, 8'h10, 1'b0);
    burst(1, 2, 8'h20, 1'b0);
    burst(0, 3, 8'h30, 1'b0);
    burst(1, 2, 8'h40, 1'b1);
    chk("div_holds_1", {16'd0, spi_clk_div_val}, 32'd9);

    // Maximum length wraps byte counter cleanly: 16 bytes.
    len = {4'd0, 4'hF}; req = 2'b01;
    burst(0, 16, 8'hC0, 1'b1);

    // Ack timeout.
    len = {4'd0, 4'd0}; req = 2'b01; set_tx(0, 8'h77);
    wait_req(n);
    chk("to_setup_delay", n, 32'd5);
    n = 0;
    while (spi_wr_req === 1'b1 && n < 100) begin
      tick;
      n++;
    end
    chk("to_wr_req_len", n, 32'd32);
    repeat (2) begin
      tick;
      chk("to_cs_hold", {31'd0, spi_cs_ctrl}, 32'd0);
    end
    tick;
    chk("to_cs_rise", {31'd0, spi_cs_ctrl}, 32'd1);
    chk("to_done", {30'd0, done}, 32'd1);
    chk("to_err", {30'd0, err}, 32'd1);
    req = 2'b00;
    tick;
    chk("to_grant_clear", {30'd0, grant}, 32'd0);

    // Reset during byte 2 of a 4-byte burst.
    len = {4'd0, 4'd3}; req = 2'b01; set_tx(0, 8'h50);
    wait_req(n);
    chk("rs_setup_delay", n, 32'd5);
    set_tx(0, 8'h51);
    xfer(0, 8'hE1, 0);
    wait_req(n);
    chk("rs_byte_gap", n, 32'd2);
    dc = done_cnt[0] + done_cnt[1];
    sys_rst = 1'b1; req = 2'b00;
    tick;
    sys_rst = 1'b0;
    chk("rs_cs", {31'd0, spi_cs_ctrl}, 32'd1);
    chk("rs_wr_req", {31'd0, spi_wr_req}, 32'd0);
    chk("rs_grant", {30'd0, grant}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    repeat (8) tick;
    chk("rs_no_done", done_cnt[0] + done_cnt[1], dc);
    len = {4'd0, 4'd0}; req = 2'b11;
    burst(0, 1, 8'h66, 1'b1);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
